// File: rtl/gcd_controller.sv
// Control FSM for a subtractive GCD datapath: loads A and B, repeatedly subtracts the
// smaller from the larger until they match, and aborts after ITER_MAX subtractions.
module gcd_controller #(
  parameter logic [15:0] ITER_MAX = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        lt,
  input  logic        gt,
  input  logic        eq,
  output logic        loada,
  output logic        loadb,
  output logic        loadp,
  output logic        clearp,
  output logic        sel1,
  output logic        sel2,
  output logic        selb,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] iters
);

  typedef enum logic [3:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    COMPARE,
    SUB_A,
    WB_A,
    SUB_B,
    WB_B,
    DONE,
    ERR
  } state_t;

  state_t state;
  state_t state_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Cleared on the run-accepting edge so iters already reads 0 during LOAD_A.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iters <= '0;
    end else if (state == IDLE && start) begin
      iters <= '0;
    end else if ((state == SUB_A || state == SUB_B) && iters != 16'hFFFF) begin
      iters <= iters + 16'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? LOAD_A : IDLE;
      LOAD_A:  state_next = LOAD_B;
      LOAD_B:  state_next = COMPARE;
      COMPARE: begin
        if (eq) begin
          state_next = DONE;
        end else if (iters == ITER_MAX) begin
          state_next = ERR;
        end else if (gt) begin
          state_next = SUB_A;
        end else if (lt) begin
          state_next = SUB_B;
        end else begin
          // No flag set is treated like lt.
          state_next = SUB_B;
        end
      end
      SUB_A:   state_next = WB_A;
      WB_A:    state_next = COMPARE;
      SUB_B:   state_next = WB_B;
      WB_B:    state_next = COMPARE;
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    loada  = 1'b0;
    loadb  = 1'b0;
    loadp  = 1'b0;
    clearp = 1'b0;
    sel1   = 1'b0;
    sel2   = 1'b0;
    selb   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    busy   = (state != IDLE);
    case (state)
      LOAD_A: begin
        selb   = 1'b0;
        loada  = 1'b1;
        clearp = 1'b1;
      end
      LOAD_B: begin
        selb  = 1'b0;
        loadb = 1'b1;
      end
      SUB_A: begin
        sel1  = 1'b0;
        sel2  = 1'b1;
        loadp = 1'b1;
      end
      WB_A: begin
        selb  = 1'b1;
        loada = 1'b1;
      end
      SUB_B: begin
        sel1  = 1'b1;
        sel2  = 1'b0;
        loadp = 1'b1;
      end
      WB_B: begin
        selb  = 1'b1;
        loadb = 1'b1;
      end
      DONE:    done = 1'b1;
      ERR:     err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: a small A/B/P datapath answers the controller, and each run
// is compared with an arithmetic subtractive-GCD reference with the same iteration limit.
module tb_gcd_controller;

  localparam logic [15:0] LIMIT = 16'd8;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        lt, gt, eq;
  logic        loada, loadb, loadp, clearp, sel1, sel2, selb;
  logic        busy, done, err;
  logic [15:0] iters;

  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [15:0] a_reg, b_reg, p_reg;
  logic [15:0] data_in, bus;
  logic [25:0] outs;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  gcd_controller #(.ITER_MAX(LIMIT)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .lt     (lt),
    .gt     (gt),
    .eq     (eq),
    .loada  (loada),
    .loadb  (loadb),
    .loadp  (loadp),
    .clearp (clearp),
    .sel1   (sel1),
    .sel2   (sel2),
    .selb   (selb),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .iters  (iters)
  );

  // Environment datapath: operand A is offered unless B is being loaded.
  assign data_in = loadb ? op_b : op_a;
  assign bus     = selb ? p_reg : data_in;
  assign lt      = (a_reg < b_reg);
  assign gt      = (a_reg > b_reg);
  assign eq      = (a_reg == b_reg);
  assign outs    = {loada, loadb, loadp, clearp, sel1, sel2, selb, busy, done, err, iters};

  always_ff @(posedge clock) begin
    if (loada) a_reg <= bus;
    if (loadb) b_reg <= bus;
    if (clearp) p_reg <= '0;
    else if (loadp) p_reg <= (sel1 ? b_reg : a_reg) - (sel2 ? b_reg : a_reg);
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: subtractive GCD with abort once LIMIT subtractions are spent.
  // sig records each step as {sel1,sel2}: 01 for A-B, 10 for B-A.
  function automatic void gcd_model(input int a0, input int b0, output int k, output int g,
                                    output bit e, output logic [31:0] sig);
    int a;
    int b;
    a = a0;
    b = b0;
    k = 0;
    e = 1'b0;
    sig = '0;
    while (a != b) begin
      if (k == int'(LIMIT)) begin
        e = 1'b1;
        break;
      end
      if (a > b) begin
        a = a - b;
        sig = {sig[29:0], 2'b01};
      end else begin
        b = b - a;
        sig = {sig[29:0], 2'b10};
      end
      k++;
    end
    g = a;
  endfunction

  // mode 0: plain run; 1: start pulsed in COMPARE and DONE; 2: start held from DONE into IDLE.
  task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b, input int mode);
    int k, g, exp_cyc, obs_cyc, loadp_cnt, both;
    bit exp_err, finished, obs_err;
    logic [31:0] exp_sig, obs_sig;
    logic [15:0] obs_iters, obs_a, obs_b;
    gcd_model(int'(a), int'(b), k, g, exp_err, exp_sig);
    exp_cyc = 4 + 3 * k;
    for (int w = 0; w < 4 && busy !== 1'b0; w++) @(negedge clock);
    check_output("idle_before_start", 32'(busy), 32'd0);
    op_a = a;
    op_b = b;
    start = 1'b1;
    finished = 1'b0;
    loadp_cnt = 0;
    both = 0;
    obs_sig = '0;
    obs_cyc = 0;
    obs_err = 1'b0;
    obs_iters = '0;
    obs_a = '0;
    obs_b = '0;
    for (int cyc = 1; cyc <= exp_cyc + 6 && !finished; cyc++) begin
      @(negedge clock);
      start = (mode == 1 && cyc == 3);
      if (loadp) begin
        loadp_cnt++;
        obs_sig = {obs_sig[29:0], sel1, sel2};
      end
      if (done && err) both++;
      if (done || err) begin
        finished = 1'b1;
        obs_cyc = cyc;
        obs_err = err;
        obs_iters = iters;
        obs_a = a_reg;
        obs_b = b_reg;
        if (mode != 0) start = 1'b1;
      end
    end
    check_output("run_finished", 32'(finished), 32'd1);
    check_output("finish_cycle", 32'(obs_cyc), 32'(exp_cyc));
    check_output("err_vs_done", 32'(obs_err), 32'(exp_err));
    check_output("done_err_exclusive", 32'(both), 32'd0);
    check_output("iters_at_end", 32'(obs_iters), 32'(k));
    check_output("loadp_count", 32'(loadp_cnt), 32'(k));
    check_output("sub_order", obs_sig, exp_sig);
    if (!exp_err) begin
      check_output("result_a", 32'(obs_a), 32'(g));
      check_output("result_b", 32'(obs_b), 32'(g));
    end
    if (mode != 2) begin
      @(negedge clock);
      start = 1'b0;
      check_output("pulse_one_cycle", 32'({done, err}), 32'd0);
      check_output("idle_after_run", 32'(busy), 32'd0);
      check_output("iters_hold", 32'(iters), 32'(k));
      if (mode == 1) begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clock);
          check_output("stray_start_ignored", 32'({busy, done, err}), 32'd0);
        end
      end
    end
  endtask

  initial begin
    bit found;
    logic [15:0] ra, rb;
    reset = 1'b1;
    start = 1'b0;
    #1;
    check_output("reset_outputs", 32'(outs), 32'd0);
    repeat (2) @(negedge clock);
    check_output("reset_hold_outputs", 32'(outs), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check_output("idle_after_reset", 32'(busy), 32'd0);

    apply_stimulus(16'd7, 16'd7, 0);
    apply_stimulus(16'd12, 16'd8, 0);
    apply_stimulus(16'd0, 16'd5, 0);
    apply_stimulus(16'd5, 16'd0, 0);
    apply_stimulus(16'd65535, 16'd1, 0);
    apply_stimulus(16'd0, 16'd0, 0);
    apply_stimulus(16'd20, 16'd15, 1);
    apply_stimulus(16'd9, 16'd6, 2);
    apply_stimulus(16'd14, 16'd21, 0);

    op_a = 16'd12;
    op_b = 16'd8;
    start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (loada && selb) found = 1'b1;
    end
    check_output("wb_a_reached", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    check_output("reset_mid_run_outputs", 32'(outs), 32'd0);
    @(negedge clock);
    check_output("reset_mid_run_hold", 32'(outs), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_output("idle_after_mid_reset", 32'({busy, done, err}), 32'd0);
    end
    apply_stimulus(16'd9, 16'd6, 0);

    for (int n = 0; n < 12; n++) begin
      ra = 16'($urandom_range(1, 40));
      rb = 16'($urandom_range(1, 40));
      apply_stimulus(ra, rb, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gcd_controller.md
GCD_CONTROLLER -- requirements
Module: gcd_controller

Interface
REQ-001 Parameter: ITER_MAX, 16'hFFFF, maximum subtractions per run before abort.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new GCD run; sampled only in IDLE.
REQ-005 lt  input  1  datapath compare, A < B.
REQ-006 gt  input  1  datapath compare, A > B.
REQ-007 eq  input  1  datapath compare, A == B.
REQ-008 loada  output  1  load register A from bus.
REQ-009 loadb  output  1  load register B from bus.
REQ-010 loadp  output  1  load subtractor result register P.
REQ-011 clearp  output  1  clear P.
REQ-012 sel1  output  1  subtractor minuend select: 0 = A, 1 = B.
REQ-013 sel2  output  1  subtractor subtrahend select: 0 = A, 1 = B.
REQ-014 selb  output  1  bus select: 0 = data_in, 1 = P.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse, result valid in A and B.
REQ-017 err  output  1  one-cycle pulse, run aborted on iteration limit.
REQ-018 iters  output  16  subtraction count of the current or last run.

Function
REQ-019 States: IDLE, LOAD_A, LOAD_B, COMPARE, SUB_A, WB_A, SUB_B, WB_B, DONE, ERR.
REQ-020 Control outputs are Moore-decoded from state only. Any control not listed for a state is 0.
REQ-021 IDLE: start=1 goes to LOAD_A; start=0 stays in IDLE.
REQ-022 LOAD_A: selb=0, loada=1, clearp=1; iters cleared to 0; next state LOAD_B. The environment presents operand A on data_in in this cycle.
REQ-023 LOAD_B: selb=0, loadb=1; next state COMPARE. The environment presents operand B on data_in in this cycle.
REQ-024 COMPARE drives no controls and decides the next state with priority eq > gt > lt:
- eq goes to DONE.
- Otherwise, iters == ITER_MAX goes to ERR.
- Otherwise, gt goes to SUB_A.
- Otherwise (lt, or no flag set) goes to SUB_B.
REQ-025 SUB_A: sel1=0, sel2=1, loadp=1 (P = A - B); iters increments by 1; next state WB_A.
REQ-026 WB_A: selb=1, loada=1 (A = P); next state COMPARE.
REQ-027 SUB_B: sel1=1, sel2=0, loadp=1 (P = B - A); iters increments by 1; next state WB_B.
REQ-028 WB_B: selb=1, loadb=1 (B = P); next state COMPARE.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE.
REQ-030 ERR: err=1 for exactly one cycle, then IDLE.
REQ-031 Latency: done is asserted in cycle 4+3k after the start-sampling edge, where k is the number of subtractions.
REQ-032 iters is 16-bit unsigned and never wraps; it holds its value through DONE, ERR and IDLE until the next LOAD_A.
REQ-033 start is ignored in all states other than IDLE, including DONE and ERR. A start held high through DONE begins a new run from the following IDLE cycle.
REQ-034 done and err are never asserted in the same cycle.

Reset
REQ-035 While reset=1, the state is IDLE and all outputs (controls, busy, done, err, iters) are 0, asynchronously and independent of clock.
REQ-036 Reset asserted mid-run aborts the run with no done or err pulse. After release, the block waits in IDLE for start.

Verification
REQ-037 A=7, B=7 (eq at first COMPARE) -> done in cycle 4, iters=0, no loadp asserted.
REQ-038 A=12, B=8 -> state sequence SUB_A, WB_A, SUB_B, WB_B; done in cycle 10; iters=2; A=B=4.
REQ-039 A=65535, B=1 with default ITER_MAX -> done after 65534 subtractions, A=B=1, err never asserted.
REQ-040 A=0, B=5 with ITER_MAX=8 -> err pulse after 8 subtractions, iters=8, done never asserted.
REQ-041 Reset pulsed during WB_A -> all outputs 0 immediately; a new start with A=9, B=6 then completes with A=B=3 and iters=2.
REQ-042 start pulsed during COMPARE and during DONE -> ignored; exactly one done per accepted start.
